// File: rtl/alu_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor and its flag generator.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  // Counter must still be one bit wide when a single slice covers the operand.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NSLICE = DEF_WIDTH / DEF_SLICE;
  localparam int unsigned CNT_W  = cnt_width(NSLICE);

endpackage

// File: rtl/alu_slice_add.sv
// Combinational SLICE-bit adder; c_msb exposes the carry into the top bit for signed overflow.
module alu_slice_add #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] lo;
  logic [1:0]       hi;

  assign lo    = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
  assign c_msb = lo[SLICE-1];
  assign hi    = {1'b0, a[SLICE-1]} + {1'b0, b[SLICE-1]} + {1'b0, c_msb};
  assign sum   = {hi[0], lo[SLICE-2:0]};
  assign cout  = hi[1];

endmodule

// File: rtl/alu_flag_gen.sv
// Slice-serial add/subtract, LSB slice first, producing Sum and Z/V/N for the compare stage.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Z,
  output logic             V,
  output logic             N
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned CW = cnt_width(NS);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             zacc;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, sign_q;

  logic [SLICE-1:0] s_sum;
  logic             s_cout, s_cmsb;
  logic             accept, last, v_c, n_c;

  alu_slice_add #(.SLICE(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .c_msb(s_cmsb)
  );

  assign last = (cnt == CW'(NS - 1));

  // Signed: overflow from carry disagreement, N is the sign of the exact result.
  // Unsigned: V is carry-out (add) or borrow (sub); N is the borrow, i.e. A<B.
  always_comb begin
    v_c = sign_q ? (s_cmsb ^ s_cout) : (s_cout ^ sub_q);
    n_c = sign_q ? (s_sum[SLICE-1] ^ v_c) : (sub_q & ~s_cout);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = RUN;
        accept     = 1'b1;
      end
      RUN:  if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: operands shift down one slice per RUN edge; Sum is filled slice by slice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sign_q <= 1'b0;
      Sum    <= '0;
      Z      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B ^ {WIDTH{Sub}};
      sub_q  <= Sub;
      sign_q <= Sign;
      carry  <= Sub;
      cnt    <= '0;
      zacc   <= 1'b1;
      Sum    <= '0;
      Z      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
    end else if (state == RUN) begin
      a_q                       <= a_q >> SLICE;
      b_q                       <= b_q >> SLICE;
      Sum[32'(cnt)*SLICE +: SLICE] <= s_sum;
      carry                     <= s_cout;
      zacc                      <= zacc & (s_sum == '0);
      cnt                       <= cnt + CW'(1);
      if (last) begin
        Z <= zacc & (s_sum == '0);
        V <= v_c;
        N <= n_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_gen.sv
// Directed-vector bench for alu_flag_gen: results, flags, latency, ignored starts and async abort.
module tb_alu_flag_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic        Sub, Sign;
  logic        busy, done, Z, V, N;
  logic [31:0] Sum;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  alu_flag_gen #(.WIDTH(32), .SLICE(8)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .B    (B),
    .Sub  (Sub),
    .Sign (Sign),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Z    (Z),
    .V    (V),
    .N    (N)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] s,
                           input logic z, input logic v, input logic n);
    check({tag, " Sum"}, Sum, s);
    check({tag, " Z"}, 32'(Z), 32'(z));
    check({tag, " V"}, 32'(V), 32'(v));
    check({tag, " N"}, 32'(N), 32'(n));
  endtask

  // Drives a request through its accepting edge, then scrambles the operand inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic sign);
    A = a; B = b; Sub = sub; Sign = sign; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; Sub = ~sub; Sign = ~sign;
  endtask

  // Waits (bounded) for done; lat = edges after the accepting edge, bcnt = busy cycles seen.
  task automatic wait_done(input string tag, output int lat, output int bcnt);
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: done timeout got none expected pulse", tag);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sign,
                        input logic [31:0] s, input logic z, input logic v, input logic n);
    int lat, bcnt;
    start_op(a, b, sub, sign);
    wait_done(tag, lat, bcnt);
    check_res(tag, s, z, v, n);
    @(posedge clk); #1;
  endtask

  int lat, bcnt, d0;

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Sub = 1'b0; Sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // 5-5 signed: timing of done/busy plus flags
    d0 = done_seen;
    start_op(32'd5, 32'd5, 1'b1, 1'b1);
    check("acc busy", 32'(busy), 32'd1);
    wait_done("eq", lat, bcnt);
    check("eq latency", 32'(lat), 32'd4);
    check_res("eq", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("eq done pulse", 32'(done), 32'd0);
    check("eq busy cycles", 32'(bcnt), 32'd5);
    check("eq idle", 32'(busy), 32'd0);
    check_res("eq hold", 32'h0, 1'b1, 1'b0, 1'b0);

    run_op("sadd ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("ssub ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("usub",     32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("usub brw", 32'h1,         32'h2, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("xcarry",   32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    run_op("uadd cout", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("done count", 32'(done_seen - d0), 32'd7);

    // starts while busy are ignored
    d0 = done_seen;
    start_op(32'd3, 32'd4, 1'b0, 1'b0);
    A = 32'd100; B = 32'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", lat, bcnt);
    check("ign latency", 32'(lat), 32'd3);
    check_res("ign", 32'd7, 1'b0, 1'b0, 1'b0);
    A = 32'd50; B = 32'd60; Sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("ign done count", 32'(done_seen - d0), 32'd1);
    check_res("ign hold", 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("after ign", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

    // async abort after two RUN edges
    d0 = done_seen;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check_res("abort", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort no done", 32'(done_seen - d0), 32'd0);
    run_op("post abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
           32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
